// File: rtl/load_store_unit_pkg.sv
// Shared CPU types for the load/store path: access sizes, LSU states and
// the store lane helpers.
package cpu_types;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } memory_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_DONE
    } lsu_state_t;

    // Size 2'd3 falls into the default arm and behaves as a word access.
    function automatic logic is_misaligned(memory_size_t size, logic [1:0] off);
        case (size)
            MEM_BYTE: is_misaligned = 1'b0;
            MEM_HALF: is_misaligned = off[0];
            default:  is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_mask(memory_size_t size, logic [1:0] off);
        case (size)
            MEM_BYTE: store_mask = 4'b0001 << off;
            MEM_HALF: store_mask = 4'b0011 << off;
            default:  store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(memory_size_t size, logic [31:0] wdata);
        case (size)
            MEM_BYTE: store_data = {4{wdata[7:0]}};
            MEM_HALF: store_data = {2{wdata[15:0]}};
            default:  store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory valid/ready bus between the load/store unit and the memory.
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_load_extender.sv
// Combinational load extraction: selects the addressed byte/half of a bus word
// and sign- or zero-extends it to 32 bits.
module load_extender
    import cpu_types::*;
(
    input  logic [31:0]  word,
    input  logic [1:0]   offset,
    input  memory_size_t size,
    input  logic         sign_ext,
    output logic [31:0]  result
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        case (size)
            MEM_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            MEM_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one data-memory access per request over a
// valid/ready bus, stalling the core until it completes, faults or times out.
module load_store_unit
    import cpu_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_we,
    input  memory_size_t req_size,
    input  logic         req_sign_ext,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         stall,
    output logic [31:0]  rdata,
    output logic         fault,
    load_store_unit_if.master mem
);

    lsu_state_t   state, state_next;
    logic         mem_valid_q, mem_valid_n;
    logic         mem_we_q, mem_we_n;
    logic [31:0]  mem_addr_q, mem_addr_n;
    logic [3:0]   mem_wmask_q, mem_wmask_n;
    logic [31:0]  mem_wdata_q, mem_wdata_n;
    logic [31:0]  rdata_q, rdata_n;
    logic         fault_q, fault_n;
    logic [31:0]  cnt_q, cnt_n;

    memory_size_t size_q;
    logic [1:0]   off_q;
    logic         sign_q;
    logic [31:0]  load_result;

    load_extender u_load_extender (
        .word     (mem.mem_rdata),
        .offset   (off_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .result   (load_result)
    );

    always_comb begin
        state_next  = state;
        mem_valid_n = mem_valid_q;
        mem_we_n    = mem_we_q;
        mem_addr_n  = mem_addr_q;
        mem_wmask_n = mem_wmask_q;
        mem_wdata_n = mem_wdata_q;
        rdata_n     = rdata_q;
        fault_n     = fault_q;
        cnt_n       = cnt_q;
        case (state)
            LSU_IDLE: begin
                mem_valid_n = 1'b0;
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        fault_n    = 1'b1;
                        rdata_n    = '0;
                        state_next = LSU_DONE;
                    end else begin
                        mem_valid_n = 1'b1;
                        mem_we_n    = req_we;
                        mem_addr_n  = {req_addr[31:2], 2'b00};
                        mem_wmask_n = req_we ? store_mask(req_size, req_addr[1:0]) : 4'b0000;
                        mem_wdata_n = store_data(req_size, req_wdata);
                        cnt_n       = '0;
                        state_next  = LSU_BUSY;
                    end
                end
            end
            LSU_BUSY: begin
                // A ready in the timeout cycle still completes the access.
                if (mem.mem_ready) begin
                    mem_valid_n = 1'b0;
                    rdata_n     = mem_we_q ? 32'd0 : load_result;
                    fault_n     = 1'b0;
                    state_next  = LSU_DONE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    mem_valid_n = 1'b0;
                    rdata_n     = '0;
                    fault_n     = 1'b1;
                    state_next  = LSU_DONE;
                end else begin
                    cnt_n = cnt_q + 32'd1;
                end
            end
            LSU_DONE: begin
                fault_n    = 1'b0;
                state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mem_valid_q <= mem_valid_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wmask_q <= mem_wmask_n;
            mem_wdata_q <= mem_wdata_n;
            rdata_q     <= rdata_n;
            fault_q     <= fault_n;
            cnt_q       <= cnt_n;
        end
    end

    // Load shape is captured at issue so req_* may change while BUSY.
    always_ff @(posedge clk) begin
        if (state == LSU_IDLE && req_valid) begin
            size_q <= req_size;
            off_q  <= req_addr[1:0];
            sign_q <= req_sign_ext;
        end
    end

    assign stall         = req_valid && (state != LSU_DONE);
    assign rdata         = rdata_q;
    assign fault         = fault_q;
    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wmask = mem_wmask_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses plus
// timeout, reset-mid-access and back-to-back sequences.
module tb_load_store_unit;
    import cpu_types::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    memory_size_t req_size = MEM_BYTE;
    logic         req_sign_ext = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic         stall;
    logic [31:0]  rdata;
    logic         fault;

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_sign_ext (req_sign_ext),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rdata        (rdata),
        .fault        (fault),
        .mem          (bus_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          waits;
        logic        chk_bus;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_fault;
        int          e_valid;
        int          e_stall;
    } vec_t;

    // Starts at a negedge in IDLE; returns at the negedge after DONE with req_valid still high.
    task automatic do_access(input logic we, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] mrd, input int waits,
                             output int valid_cycles, output int stall_cycles,
                             output logic [31:0] o_addr, output logic [3:0] o_mask,
                             output logic [31:0] o_wdata, output logic o_we,
                             output logic [31:0] o_rdata, output logic o_fault,
                             output logic done_ok);
        req_we           = we;
        req_size         = memory_size_t'(size);
        req_sign_ext     = sext;
        req_addr         = addr;
        req_wdata        = wdata;
        req_valid        = 1'b1;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = mrd;
        valid_cycles = 0;
        stall_cycles = 0;
        done_ok      = 1'b0;
        o_addr = '0; o_mask = '0; o_wdata = '0; o_we = 1'b0; o_rdata = '0; o_fault = 1'b0;
        for (int c = 0; c < 64 && !done_ok; c++) begin
            #1;
            if (!stall) begin
                done_ok = 1'b1;
                o_rdata = rdata;
                o_fault = fault;
                bus_if.mem_ready = 1'b0;
            end else begin
                stall_cycles++;
                if (bus_if.mem_valid) begin
                    o_addr  = bus_if.mem_addr;
                    o_mask  = bus_if.mem_wmask;
                    o_wdata = bus_if.mem_wdata;
                    o_we    = bus_if.mem_we;
                    bus_if.mem_ready = (waits >= 0) && (valid_cycles == waits);
                    valid_cycles++;
                end else begin
                    bus_if.mem_ready = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!done_ok) begin
            checks++;
            failures++;
            $display("FAIL access_timeout addr=%h no DONE within 64 cycles", addr);
        end
        @(negedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        int          vc, sc;
        logic [31:0] oa, ow, ord;
        logic [3:0]  om;
        logic        owe, of, ok;

        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = '0;

        vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, 1, 2};
        vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 1'b1, 32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 4, 5};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 1'b1, 32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001, 1'b0, 4, 5};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 2};
        vecs[4]  = '{1'b0, 2'd2, 1'b1, 32'h0000_3001, 32'h0, 32'h1111_1111, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 1};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 1, 1'b1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 2, 3};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0021, 32'h0, 32'h1234_F300, 2, 1'b1, 32'h0000_0020, 4'b0000, 32'h0, 32'hFFFF_FFF3, 1'b0, 3, 4};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0023, 32'h0, 32'h9A00_0000, 0, 1'b1, 32'h0000_0020, 4'b0000, 32'h0, 32'h0000_009A, 1'b0, 1, 2};
        vecs[8]  = '{1'b0, 2'd2, 1'b1, 32'h0000_0040, 32'h0, 32'h8000_0001, 1, 1'b1, 32'h0000_0040, 4'b0000, 32'h0, 32'h8000_0001, 1'b0, 2, 3};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h0000_5555, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 1};
        vecs[10] = '{1'b0, 2'd3, 1'b1, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 32'h0000_0044, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 2};
        vecs[11] = '{1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'hFFFF_FF5A, 32'h0, 0, 1'b1, 32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0, 1, 2};

        // Reset state
        #2;
        check32("rst_mem_valid", {31'd0, bus_if.mem_valid}, 32'd0);
        check32("rst_mem_wmask", {28'd0, bus_if.mem_wmask}, 32'd0);
        check32("rst_mem_addr", bus_if.mem_addr, 32'd0);
        check32("rst_rdata", rdata, 32'd0);
        check32("rst_fault", {31'd0, fault}, 32'd0);
        check32("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                      vecs[i].mrd, vecs[i].waits, vc, sc, oa, om, ow, owe, ord, of, ok);
            req_valid = 1'b0;
            check32($sformatf("v%0d_valid_cycles", i), 32'(vc), 32'(vecs[i].e_valid));
            check32($sformatf("v%0d_stall_cycles", i), 32'(sc), 32'(vecs[i].e_stall));
            check32($sformatf("v%0d_rdata", i), ord, vecs[i].e_rdata);
            check32($sformatf("v%0d_fault", i), {31'd0, of}, {31'd0, vecs[i].e_fault});
            if (vecs[i].chk_bus) begin
                check32($sformatf("v%0d_mem_addr", i), oa, vecs[i].e_addr);
                check32($sformatf("v%0d_mem_wmask", i), {28'd0, om}, {28'd0, vecs[i].e_mask});
                check32($sformatf("v%0d_mem_we", i), {31'd0, owe}, {31'd0, vecs[i].we});
                if (vecs[i].we)
                    check32($sformatf("v%0d_mem_wdata", i), ow, vecs[i].e_wdata);
            end
            #1;
            check32($sformatf("v%0d_fault_cleared", i), {31'd0, fault}, 32'd0);
            check32($sformatf("v%0d_rdata_hold", i), rdata, vecs[i].e_rdata);
            check32($sformatf("v%0d_idle_valid", i), {31'd0, bus_if.mem_valid}, 32'd0);
            @(negedge clk);
        end

        // Timeout with a silent memory
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678, -1,
                  vc, sc, oa, om, ow, owe, ord, of, ok);
        req_valid = 1'b0;
        check32("to_valid_cycles", 32'(vc), 32'd4);
        check32("to_stall_cycles", 32'(sc), 32'd5);
        check32("to_fault", {31'd0, of}, 32'd1);
        check32("to_rdata", ord, 32'd0);
        #1;
        check32("to_fault_cleared", {31'd0, fault}, 32'd0);
        check32("to_idle_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);

        // Reset while BUSY with a word store outstanding
        req_we = 1'b1; req_size = MEM_WORD; req_sign_ext = 1'b0;
        req_addr = 32'h0000_0040; req_wdata = 32'h0BAD_F00D; req_valid = 1'b1;
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        check32("rm_busy_valid", {31'd0, bus_if.mem_valid}, 32'd1);
        check32("rm_busy_wmask", {28'd0, bus_if.mem_wmask}, 32'hF);
        #2;
        rst = 1'b1;
        #1;
        check32("rm_async_valid", {31'd0, bus_if.mem_valid}, 32'd0);
        check32("rm_async_wmask", {28'd0, bus_if.mem_wmask}, 32'd0);
        check32("rm_async_addr", bus_if.mem_addr, 32'd0);
        req_valid = 1'b0;
        #1;
        check32("rm_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_007F, 0,
                  vc, sc, oa, om, ow, owe, ord, of, ok);
        req_valid = 1'b0;
        check32("rm_load_rdata", ord, 32'h0000_007F);
        check32("rm_load_stall", 32'(sc), 32'd2);
        check32("rm_load_fault", {31'd0, of}, 32'd0);
        @(negedge clk);

        // Back-to-back store then load, zero-wait memory
        do_access(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'h1357_9BDF, 32'h0, 0,
                  vc, sc, oa, om, ow, owe, ord, of, ok);
        check32("b2b_st_cycles", 32'(sc + 1), 32'd3);
        check32("b2b_st_wdata", ow, 32'h1357_9BDF);
        do_access(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 0,
                  vc, sc, oa, om, ow, owe, ord, of, ok);
        req_valid = 1'b0;
        check32("b2b_ld_cycles", 32'(sc + 1), 32'd3);
        check32("b2b_ld_rdata", ord, 32'h0000_BEEF);
        check32("b2b_ld_addr", oa, 32'h0000_0200);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
